uart_bus_rtl: RTL and testbench

- Synthesizable serial UART endpoint paired with the cva6_zybo_z7_20 platform's UART pins.
- Its `rx` connects to the platform `tx`; its `tx` connects to the platform `rx`.
- Deserializes platform console output into bytes and serializes host bytes back to the platform.
- Default rate is 115200 baud from the 125 MHz (8 ns) platform clock.

---
 rtl/uart_bus_rtl.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_uart_bus_rtl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_rtl.sv
// uart_bus_rtl: serial UART endpoint for the platform console pins.
// rx deserializes platform output into bytes; tx serializes host bytes back.
// Frame: start(0), 8 data bits LSB first, optional even parity, 1 stop(1).
module uart_bus_rtl #(
   parameter int CLK_FREQ  = 125000000,
   parameter int BAUD_RATE = 115200,
   parameter int PARITY_EN = 0
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       rx,
   output logic       tx,
   input  logic       rx_en,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_parity_err,
   output logic       rx_frame_err,
   output logic       rx_eol,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready
);

   // Bit timing derived from the clock; truncation matches the platform side.
   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
   localparam bit PAR_ON = (PARITY_EN != 0);

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_e;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_e;

   // ------------------------------------------------------------------
   // Receive path
   // ------------------------------------------------------------------
   logic             rx_meta_q;
   logic             rx_sync_q;
   rx_state_e        rx_state_q, rx_state_d;
   logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]       rx_bit_q, rx_bit_d;
   logic [7:0]       rx_shift_q, rx_shift_d;
   logic             rx_par_q, rx_par_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic             rx_perr_q, rx_perr_d;
   logic             rx_ferr_q, rx_ferr_d;
   logic             rx_eol_q, rx_eol_d;

   // Two-flop synchronizer; idles high so reset does not look like a start bit.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
      end
   end

   // Receiver state and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_par_q   <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_perr_q  <= 1'b0;
         rx_ferr_q  <= 1'b0;
         rx_eol_q   <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_par_q   <= rx_par_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_perr_q  <= rx_perr_d;
         rx_ferr_q  <= rx_ferr_d;
         rx_eol_q   <= rx_eol_d;
      end
   end

   // Receiver next state: mid-bit sampling, outputs published after the stop sample.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_par_d   = rx_par_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      rx_perr_d  = rx_perr_q;
      rx_ferr_d  = rx_ferr_q;
      rx_eol_d   = 1'b0;
      unique case (rx_state_q)
         RX_IDLE: begin
            // rx_en only gates new frames; a frame already started runs to completion.
            if (rx_en && !rx_sync_q) begin
               rx_state_d = RX_START;
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_par_d   = 1'b0;
            end
         end
         RX_START: begin
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d   = '0;
               // A line back high at mid start bit is a glitch, not a frame.
               rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = PAR_ON ? RX_PARITY : RX_STOP;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RX_PARITY: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_par_d   = rx_sync_q ^ (^rx_shift_q);
               rx_state_d = RX_STOP;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == BIT_LAST) begin
               // Back to IDLE at mid stop bit so a following start edge is not missed.
               rx_cnt_d   = '0;
               rx_state_d = RX_IDLE;
               rx_data_d  = rx_shift_q;
               rx_valid_d = 1'b1;
               rx_perr_d  = rx_par_q;
               rx_ferr_d  = ~rx_sync_q;
               rx_eol_d   = (rx_shift_q == 8'h0A);
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         default: begin
            rx_state_d = RX_IDLE;
         end
      endcase
   end

   assign rx_data       = rx_data_q;
   assign rx_valid      = rx_valid_q;
   assign rx_parity_err = rx_perr_q;
   assign rx_frame_err  = rx_ferr_q;
   assign rx_eol        = rx_eol_q;

   // ------------------------------------------------------------------
   // Transmit path
   // ------------------------------------------------------------------
   tx_state_e        tx_state_q, tx_state_d;
   logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]       tx_bit_q, tx_bit_d;
   logic [7:0]       tx_shift_q, tx_shift_d;
   logic             tx_par_q, tx_par_d;
   logic             tx_line_q, tx_line_d;
   logic             tx_ready_q, tx_ready_d;

   // Transmitter state; line and ready are registered so they are glitch-free.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_par_q   <= 1'b0;
         tx_line_q  <= 1'b1;
         tx_ready_q <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_par_q   <= tx_par_d;
         tx_line_q  <= tx_line_d;
         tx_ready_q <= tx_ready_d;
      end
   end

   // Transmitter next state: the level for the next bit is chosen at the end of the current one.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_par_d   = tx_par_q;
      tx_line_d  = tx_line_q;
      tx_ready_d = tx_ready_q;
      unique case (tx_state_q)
         TX_IDLE: begin
            tx_line_d = 1'b1;
            if (tx_valid && tx_ready_q) begin
               // Byte is copied here so later tx_data changes cannot disturb the frame.
               tx_shift_d = tx_data;
               tx_par_d   = ^tx_data;
               tx_cnt_d   = '0;
               tx_line_d  = 1'b0;
               tx_ready_d = 1'b0;
               tx_state_d = TX_START;
            end
         end
         TX_START: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_line_d  = tx_shift_q[0];
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               tx_state_d = TX_DATA;
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         TX_DATA: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d = '0;
               if (tx_bit_q == 3'd7) begin
                  tx_line_d  = PAR_ON ? tx_par_q : 1'b1;
                  tx_state_d = PAR_ON ? TX_PARITY : TX_STOP;
               end else begin
                  tx_bit_d   = tx_bit_q + 3'd1;
                  tx_line_d  = tx_shift_q[0];
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
               end
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         TX_PARITY: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_line_d  = 1'b1;
               tx_state_d = TX_STOP;
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         TX_STOP: begin
            if (tx_cnt_q == BIT_LAST) begin
               // Ready rises right after the last stop cycle, allowing back-to-back frames.
               tx_cnt_d   = '0;
               tx_line_d  = 1'b1;
               tx_ready_d = 1'b1;
               tx_state_d = TX_IDLE;
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         default: begin
            tx_state_d = TX_IDLE;
            tx_line_d  = 1'b1;
            tx_ready_d = 1'b1;
         end
      endcase
   end

   assign tx       = tx_line_q;
   assign tx_ready = tx_ready_q;

endmodule

// File: tb/tb_uart_bus_rtl.sv
// Testbench for uart_bus_rtl: two instances (without / with parity) at a short
// bit period. Stimulus pushes expected results into per-instance queues; a
// monitor per instance pops and compares every cycle.
module tb_uart_bus_rtl;

   localparam int CLK_FREQ = 1600000;
   localparam int BAUD     = 100000;
   localparam int CPB      = CLK_FREQ / BAUD;   // 16 clocks per bit

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic       rx_drv     [2];
   logic       loop_en    [2];
   logic       rx_en_s    [2];
   logic       tx_valid_s [2];
   logic [7:0] tx_data_s  [2];
   logic       tx_w       [2];
   logic       tx_ready_w [2];
   logic [7:0] rx_data_w  [2];
   logic       rx_valid_w [2];
   logic       rx_perr_w  [2];
   logic       rx_ferr_w  [2];
   logic       rx_eol_w   [2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      logic        rx_in;
      logic [1:0]  tx_exp [$];     // per cycle {tx, tx_ready}
      logic [10:0] rx_exp [$];     // {data, parity_err, frame_err, eol}
      logic [10:0] rx_last = '0;

      assign rx_in = loop_en[gi] ? tx_w[gi] : rx_drv[gi];

      uart_bus_rtl #(
         .CLK_FREQ (CLK_FREQ),
         .BAUD_RATE(BAUD),
         .PARITY_EN(gi)
      ) dut (
         .clk_i        (clk),
         .rst_ni       (rst_n),
         .rx           (rx_in),
         .tx           (tx_w[gi]),
         .rx_en        (rx_en_s[gi]),
         .rx_data      (rx_data_w[gi]),
         .rx_valid     (rx_valid_w[gi]),
         .rx_parity_err(rx_perr_w[gi]),
         .rx_frame_err (rx_ferr_w[gi]),
         .rx_eol       (rx_eol_w[gi]),
         .tx_data      (tx_data_s[gi]),
         .tx_valid     (tx_valid_s[gi]),
         .tx_ready     (tx_ready_w[gi])
      );

      always @(negedge clk) begin
         automatic logic [1:0]  te;
         automatic logic [10:0] re;
         automatic logic [10:0] ra;
         ra = {rx_data_w[gi], rx_perr_w[gi], rx_ferr_w[gi], rx_eol_w[gi]};
         if (!rst_n) begin
            rx_last <= '0;
            check($sformatf("reset%0d tx/ready", gi), 32'({tx_w[gi], tx_ready_w[gi]}), 32'd3);
            check($sformatf("reset%0d rx outputs", gi), 32'({rx_valid_w[gi], ra}), 32'd0);
         end else begin
            te = (tx_exp.size() != 0) ? tx_exp.pop_front() : 2'b11;
            check($sformatf("tx%0d line/ready", gi), 32'({tx_w[gi], tx_ready_w[gi]}), 32'(te));
            if (rx_valid_w[gi]) begin
               check($sformatf("rx%0d valid expected", gi), 32'(rx_exp.size() != 0), 32'd1);
               if (rx_exp.size() != 0) begin
                  re = rx_exp.pop_front();
                  check($sformatf("rx%0d byte/flags", gi), 32'(ra), 32'(re));
                  rx_last <= {re[10:1], 1'b0};
               end
            end else begin
               check($sformatf("rx%0d hold", gi), 32'(ra), 32'({rx_last[10:1], 1'b0}));
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_tx(input int d, input logic [1:0] e);
      if (d == 0) g_dut[0].tx_exp.push_back(e);
      else        g_dut[1].tx_exp.push_back(e);
   endtask

   task automatic push_rx(input int d, input logic [10:0] e);
      if (d == 0) g_dut[0].rx_exp.push_back(e);
      else        g_dut[1].rx_exp.push_back(e);
   endtask

   // Drive one serial frame into instance d; expectation follows the frame rules.
   task automatic rx_frame(input int d, input logic [7:0] v, input logic pflip,
                           input logic stopv, input logic expect_out);
      if (expect_out)
         push_rx(d, {v, (d == 1) ? pflip : 1'b0, ~stopv, (v == 8'h0A)});
      rx_drv[d] = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_drv[d] = v[i];
         tick(CPB);
      end
      if (d == 1) begin
         rx_drv[d] = (^v) ^ pflip;
         tick(CPB);
      end
      rx_drv[d] = stopv;
      tick(CPB);
      rx_drv[d] = 1'b1;
      tick(2 * CPB);
   endtask

   // Request one byte; the expected line waveform is the frame bits held CPB cycles each.
   task automatic tx_send(input int d, input logic [7:0] v);
      int t;
      logic [10:0] bits;
      int nb;
      t = 0;
      while (!tx_ready_w[d] && t < 30 * CPB) begin
         tick(1);
         t++;
      end
      check($sformatf("tx%0d ready before send", d), 32'(tx_ready_w[d]), 32'd1);
      if (!tx_ready_w[d]) return;
      bits = {1'b1, (d == 1) ? ^v : 1'b1, v, 1'b0};
      nb   = (d == 1) ? 11 : 10;
      tx_data_s[d]  = v;
      tx_valid_s[d] = 1'b1;
      push_tx(d, 2'b11);
      for (int b = 0; b < nb; b++)
         for (int c = 0; c < CPB; c++)
            push_tx(d, {bits[b], 1'b0});
      tick(1);
      tx_valid_s[d] = 1'b0;
      tx_data_s[d]  = 8'($urandom);
   endtask

   task automatic tx_drain(input int d);
      int t;
      t = 0;
      while (!tx_ready_w[d] && t < 30 * CPB) begin
         tick(1);
         t++;
      end
      check($sformatf("tx%0d drained", d), 32'(tx_ready_w[d]), 32'd1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         rx_drv[d]     = 1'b1;
         loop_en[d]    = 1'b0;
         rx_en_s[d]    = 1'b1;
         tx_valid_s[d] = 1'b0;
         tx_data_s[d]  = 8'h00;
      end
      rst_n = 1'b0;
      tick(4);
      rst_n = 1'b1;
      tick(2);

      // Basic receive, end-of-line marker.
      rx_frame(0, 8'h55, 1'b0, 1'b1, 1'b1);
      rx_frame(0, 8'h0A, 1'b0, 1'b1, 1'b1);
      // Short low glitch must not produce a byte.
      rx_drv[0] = 1'b0;
      tick(4);
      rx_drv[0] = 1'b1;
      tick(12 * CPB);
      rx_frame(0, 8'h3C, 1'b0, 1'b1, 1'b1);
      // Framing error then recovery.
      rx_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
      rx_frame(0, 8'h12, 1'b0, 1'b1, 1'b1);
      // Disabled receiver ignores a whole frame.
      rx_en_s[0] = 1'b0;
      rx_frame(0, 8'h99, 1'b0, 1'b1, 1'b0);
      rx_en_s[0] = 1'b1;
      // Dropping rx_en mid-frame does not abort it.
      fork
         rx_frame(0, 8'h81, 1'b0, 1'b1, 1'b1);
         begin
            tick(3 * CPB);
            rx_en_s[0] = 1'b0;
            tick(5 * CPB);
            rx_en_s[0] = 1'b1;
         end
      join

      // Transmit a known byte, then concurrent random rx/tx traffic.
      tx_send(0, 8'hA5);
      tx_drain(0);
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               automatic logic [7:0] v = 8'($urandom);
               automatic logic sv = ($urandom_range(0, 3) != 0);
               rx_frame(0, v, 1'b0, sv, 1'b1);
            end
         end
         begin
            for (int i = 0; i < 4; i++) tx_send(0, 8'($urandom));
            tx_drain(0);
         end
      join

      // Parity instance: loopback, flipped parity, then random traffic.
      loop_en[1] = 1'b1;
      push_rx(1, {8'h07, 1'b0, 1'b0, 1'b0});
      tx_send(1, 8'h07);
      tx_drain(1);
      tick(2 * CPB);
      loop_en[1] = 1'b0;
      rx_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               automatic logic [7:0] v = 8'($urandom);
               automatic logic pf = 1'($urandom);
               automatic logic sv = ($urandom_range(0, 3) != 0);
               rx_frame(1, v, pf, sv, 1'b1);
            end
         end
         begin
            for (int i = 0; i < 3; i++) tx_send(1, 8'($urandom));
            tx_drain(1);
         end
      join

      // Asynchronous reset in the middle of a transmission.
      tx_send(0, 8'hC3);
      tick(5 * CPB);
      rst_n = 1'b0;
      g_dut[0].tx_exp.delete();
      #1;
      check("async reset tx/ready", 32'({tx_w[0], tx_ready_w[0]}), 32'd3);
      tick(3);
      rst_n = 1'b1;
      tick(2);
      tx_send(0, 8'h5A);
      tx_drain(0);

      tick(4 * CPB);
      check("tx0 queue empty", 32'(g_dut[0].tx_exp.size()), 32'd0);
      check("tx1 queue empty", 32'(g_dut[1].tx_exp.size()), 32'd0);
      check("rx0 queue empty", 32'(g_dut[0].rx_exp.size()), 32'd0);
      check("rx1 queue empty", 32'(g_dut[1].rx_exp.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
